mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter LINE_W, default 256, cache-line width in bits.
REQ-002 Parameter ADDR_W, default 32, byte-address width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-005 icache_read_i  input  1  I-cache line-fill request.
REQ-006 icache_address_i  input  ADDR_W  I-cache line address.
REQ-007 icache_rdata_o  output  LINE_W  fill data to I-cache.
REQ-008 icache_resp_o  output  1  one-cycle completion pulse to I-cache; also feeds the pipeline stall controller as instr_mem_resp.
REQ-009 dcache_read_i  input  1  D-cache line-fill request.
REQ-010 dcache_write_i  input  1  D-cache write-back request.
REQ-011 dcache_address_i  input  ADDR_W  D-cache line address.
REQ-012 dcache_wdata_i  input  LINE_W  write-back data.
REQ-013 dcache_rdata_o  output  LINE_W  fill data to D-cache.
REQ-014 dcache_resp_o  output  1  one-cycle completion pulse to D-cache; also feeds the stall controller as data_mem_resp.
REQ-015 pmem_read_o  output  1  physical-memory read command.
REQ-016 pmem_write_o  output  1  physical-memory write command.
REQ-017 pmem_address_o  output  ADDR_W  physical-memory line address.
REQ-018 pmem_wdata_o  output  LINE_W  physical-memory write data.
REQ-019 pmem_rdata_i  input  LINE_W  physical-memory read data, valid with pmem_resp_i.
REQ-020 pmem_resp_i  input  1  physical-memory completion pulse.

Function
REQ-021 FSM states: IDLE, SERVE_I, SERVE_D, DONE.
REQ-022 IDLE: a D request (read or write) and no I request -> SERVE_D; an I request and no D request -> SERVE_I; no request -> stay in IDLE.
REQ-023 IDLE with both requests: grant the requester not granted last (last_grant register, reset value = I, so D wins the first tie).
REQ-024 On each transition out of IDLE: latch the grantee's address, the op (write if dcache_write_i=1, else read) and, for writes, dcache_wdata_i into internal registers.
REQ-025 dcache_read_i and dcache_write_i both 1: write wins; no read is issued for that grant.
REQ-026 SERVE_x: pmem_read_o or pmem_write_o held at 1 from the latched op; pmem_address_o and pmem_wdata_o driven from the latches and stable until pmem_resp_i.
REQ-027 pmem command outputs go high the cycle after the grant (one cycle of arbitration latency).
REQ-028 In SERVE_x with pmem_resp_i=1: the grantee's resp_o is 1 in that same cycle; its rdata_o = pmem_rdata_i (combinational passthrough); next state = DONE.
REQ-029 DONE lasts exactly one cycle, with all pmem commands 0 and both resp_o 0, then returns to IDLE; this prevents re-granting a request the cache has not yet dropped.
REQ-030 A request withdrawn mid-service does not abort the transaction: the command is held until pmem_resp_i and the resp pulse is still issued.
REQ-031 pmem_resp_i in IDLE or DONE is ignored; no resp_o is generated.
REQ-032 pmem_read_o and pmem_write_o are never 1 simultaneously; icache_resp_o and dcache_resp_o are never 1 simultaneously.
REQ-033 rdata_o of a port not currently responding = 0.
REQ-034 Requests arriving while not in IDLE are held off and evaluated on return to IDLE.

Reset
REQ-035 rst=0 forces, immediately: state=IDLE, last_grant=I, latches=0, all outputs 0.
REQ-036 Reset mid-transaction drops the pmem command with no resp pulse; after reset release the arbiter starts in IDLE.

Verification
REQ-037 I-only read at 0x0000_1000, pmem resp after 5 cycles -> pmem_read_o=1 for cycles 1-5, icache_resp_o pulses with the data, DONE, IDLE.
REQ-038 D write at 0x8000_0040 with wdata=0xA5 pattern -> pmem_write_o=1, address and data stable until resp, dcache_resp_o pulse, icache_resp_o stays 0.
REQ-039 I and D requesting at the same time from reset -> D served first, then I is granted on the first IDLE cycle after DONE; a repeated tie alternates.
REQ-040 dcache_read_i and dcache_write_i both 1 -> only pmem_write_o asserts.
REQ-041 rst=0 asserted during SERVE_I -> all outputs 0 at once, no resp; a new request after release is served normally.
REQ-042 Spurious pmem_resp_i in IDLE -> no resp_o and no state change.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port cache-line arbiter (I-cache / D-cache) onto one physical memory port
// Ties alternate via last_grant; a one-cycle DONE state keeps a not-yet-dropped request from being re-granted.
module mem_arbiter #(
  parameter int LINE_W = 256,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_read_i,
  input  logic [ADDR_W-1:0] icache_address_i,
  output logic [LINE_W-1:0] icache_rdata_o,
  output logic              icache_resp_o,
  input  logic              dcache_read_i,
  input  logic              dcache_write_i,
  input  logic [ADDR_W-1:0] dcache_address_i,
  input  logic [LINE_W-1:0] dcache_wdata_i,
  output logic [LINE_W-1:0] dcache_rdata_o,
  output logic              dcache_resp_o,
  output logic              pmem_read_o,
  output logic              pmem_write_o,
  output logic [ADDR_W-1:0] pmem_address_o,
  output logic [LINE_W-1:0] pmem_wdata_o,
  input  logic [LINE_W-1:0] pmem_rdata_i,
  input  logic              pmem_resp_i
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t state;
  logic   last_d;
  logic   d_req;
  logic   grant_d;

  assign d_req   = dcache_read_i | dcache_write_i;
  // D wins unless the I side also requests and D was the previous grantee.
  assign grant_d = d_req && (!icache_read_i || !last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      last_d         <= 1'b0;
      pmem_read_o    <= 1'b0;
      pmem_write_o   <= 1'b0;
      pmem_address_o <= '0;
      pmem_wdata_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (d_req || icache_read_i) begin
            last_d         <= grant_d;
            state          <= grant_d ? SERVE_D : SERVE_I;
            pmem_address_o <= grant_d ? dcache_address_i : icache_address_i;
            if (grant_d && dcache_write_i) begin
              pmem_write_o <= 1'b1;
              pmem_wdata_o <= dcache_wdata_i;
            end else begin
              pmem_read_o  <= 1'b1;
            end
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp_i) begin
            state        <= DONE;
            pmem_read_o  <= 1'b0;
            pmem_write_o <= 1'b0;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Completion is combinational so the cache sees data in the same cycle as pmem_resp_i.
  assign icache_resp_o  = (state == SERVE_I) && pmem_resp_i;
  assign dcache_resp_o  = (state == SERVE_D) && pmem_resp_i;
  assign icache_rdata_o = icache_resp_o ? pmem_rdata_i : '0;
  assign dcache_rdata_o = dcache_resp_o ? pmem_rdata_i : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed plus randomized transaction-level checks of mem_arbiter
// Expected grants come from a transaction model: tie goes to whoever was not granted last.
module tb_mem_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_rd, d_rd, d_wr, pmem_resp_i;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, pmem_rdata_i;
  logic [LW-1:0] icache_rdata_o, dcache_rdata_o, pmem_wdata_o;
  logic          icache_resp_o, dcache_resp_o, pmem_read_o, pmem_write_o;
  logic [AW-1:0] pmem_address_o;

  int total  = 0;
  int passed = 0;
  bit last_was_d;

  always #5 clk = ~clk;

  mem_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .icache_read_i(i_rd), .icache_address_i(i_addr),
    .icache_rdata_o(icache_rdata_o), .icache_resp_o(icache_resp_o),
    .dcache_read_i(d_rd), .dcache_write_i(d_wr),
    .dcache_address_i(d_addr), .dcache_wdata_i(d_wdata),
    .dcache_rdata_o(dcache_rdata_o), .dcache_resp_o(dcache_resp_o),
    .pmem_read_o(pmem_read_o), .pmem_write_o(pmem_write_o),
    .pmem_address_o(pmem_address_o), .pmem_wdata_o(pmem_wdata_o),
    .pmem_rdata_i(pmem_rdata_i), .pmem_resp_i(pmem_resp_i)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [LW-1:0] rnd_line();
    logic [LW-1:0] v;
    for (int w = 0; w < LW / 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic check_quiet_resp(input string tag);
    check({tag, "_iresp"}, icache_resp_o, 1'b0);
    check({tag, "_dresp"}, dcache_resp_o, 1'b0);
    check({tag, "_irdata"}, icache_rdata_o, '0);
    check({tag, "_drdata"}, dcache_rdata_o, '0);
  endtask

  // Entered at a negedge with the DUT in IDLE and at least one request up.
  task automatic txn(input int lat, input bit withdraw, input bit raise_other, input bit spur_done);
    bit            gd, wr;
    logic [AW-1:0] ea;
    logic [LW-1:0] ewd, rd;
    gd  = (d_rd || d_wr) && (!i_rd || !last_was_d);
    wr  = gd && d_wr;
    ea  = gd ? d_addr : i_addr;
    ewd = d_wdata;
    last_was_d = gd;
    check("idle_rd", pmem_read_o, 1'b0);
    check("idle_wr", pmem_write_o, 1'b0);
    @(posedge clk); @(negedge clk);
    for (int k = 1; k <= lat; k++) begin
      check("cmd_rd", pmem_read_o, !wr);
      check("cmd_wr", pmem_write_o, wr);
      check("cmd_addr", pmem_address_o, ea);
      if (wr) check("cmd_wdata", pmem_wdata_o, ewd);
      check_quiet_resp("serve");
      if (k == 1 && withdraw) begin
        if (gd) begin d_rd = 1'b0; d_wr = 1'b0; end else i_rd = 1'b0;
      end
      if (k == 1 && raise_other) begin
        if (gd) begin i_rd = 1'b1; i_addr = $urandom; end
        else if (!d_rd && !d_wr) begin d_rd = 1'b1; d_addr = $urandom; end
      end
      if (k < lat) begin @(posedge clk); @(negedge clk); end
    end
    rd = rnd_line();
    pmem_rdata_i = rd;
    pmem_resp_i  = 1'b1;
    #1;
    check("resp_i", icache_resp_o, !gd);
    check("resp_d", dcache_resp_o, gd);
    check("rdata_i", icache_rdata_o, gd ? '0 : rd);
    check("rdata_d", dcache_rdata_o, gd ? rd : '0);
    @(posedge clk); @(negedge clk);
    pmem_resp_i = spur_done;
    if (gd) begin d_rd = 1'b0; d_wr = 1'b0; end else i_rd = 1'b0;
    #1;
    check("done_rd", pmem_read_o, 1'b0);
    check("done_wr", pmem_write_o, 1'b0);
    check_quiet_resp("done");
    @(posedge clk); @(negedge clk);
    pmem_resp_i = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog total=%0d", total);
    $fatal(1);
  end

  initial begin
    rst = 1'b0; i_rd = 0; d_rd = 0; d_wr = 0; pmem_resp_i = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata_i = '0;
    last_was_d = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_rd", pmem_read_o, 1'b0);
    check("rst_wr", pmem_write_o, 1'b0);
    check("rst_addr", pmem_address_o, '0);
    check("rst_wdata", pmem_wdata_o, '0);
    check_quiet_resp("rst");
    rst = 1'b1;
    @(negedge clk);

    i_rd = 1'b1; i_addr = 32'h0000_1000;
    txn(5, 0, 0, 0);

    d_wr = 1'b1; d_addr = 32'h8000_0040; d_wdata = {(LW/8){8'hA5}};
    txn(3, 0, 0, 1);

    pmem_resp_i = 1'b1;
    #1 check_quiet_resp("spur_idle");
    @(posedge clk); @(negedge clk);
    check("spur_rd", pmem_read_o, 1'b0);
    check("spur_wr", pmem_write_o, 1'b0);
    pmem_resp_i = 1'b0;

    i_rd = 1'b1; i_addr = 32'h0000_2000;
    @(posedge clk); @(negedge clk);
    @(posedge clk); @(negedge clk);
    check("pre_rst_rd", pmem_read_o, 1'b1);
    rst = 1'b0; pmem_resp_i = 1'b1; pmem_rdata_i = rnd_line();
    #1;
    check("mid_rst_rd", pmem_read_o, 1'b0);
    check("mid_rst_wr", pmem_write_o, 1'b0);
    check("mid_rst_addr", pmem_address_o, '0);
    check_quiet_resp("mid_rst");
    i_rd = 1'b0; pmem_resp_i = 1'b0;
    @(negedge clk);
    rst = 1'b1; last_was_d = 1'b0;
    @(negedge clk);

    i_rd = 1'b1; i_addr = 32'h0000_3000; d_rd = 1'b1; d_addr = 32'h8000_1000;
    txn(2, 0, 0, 0);
    txn(2, 0, 0, 0);
    i_rd = 1'b1; d_rd = 1'b1;
    txn(1, 0, 0, 0);
    txn(1, 0, 0, 0);

    d_rd = 1'b1; d_wr = 1'b1; d_addr = 32'h8000_2000; d_wdata = rnd_line();
    txn(2, 0, 0, 0);

    i_rd = 1'b1; i_addr = 32'h0000_4000;
    txn(3, 1, 1, 0);
    if (i_rd || d_rd || d_wr) txn(2, 0, 0, 0);
    if (i_rd || d_rd || d_wr) txn(2, 0, 0, 0);

    for (int n = 0; n < 60; n++) begin
      if (!i_rd && $urandom_range(0, 1) == 1) begin i_rd = 1'b1; i_addr = $urandom; end
      if (!d_rd && !d_wr && $urandom_range(0, 1) == 1) begin
        d_rd = 1'(($urandom_range(0, 2)) != 0);
        d_wr = 1'(($urandom_range(0, 2)) == 0);
        d_addr = $urandom; d_wdata = rnd_line();
      end
      if (!i_rd && !d_rd && !d_wr) begin i_rd = 1'b1; i_addr = $urandom; end
      txn($urandom_range(1, 6), 1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
